// File: rtl/traffic_ctrl.sv
// Round-robin traffic-light sequencer: ALLRED -> GREEN -> YELLOW per group, with pedestrian extension and flash override.
// Latency: light/walk/state_o/cur_dir are registered and change on the tick edge that causes a transition.
// Backpressure: none; the timebase advances only on tick and ped_req is latched, so no request is lost.
module traffic_ctrl #(
    parameter int N_DIR    = 2,
    parameter int CNT_W    = 8,
    parameter int GREEN_T  = 20,
    parameter int YELLOW_T = 4,
    parameter int ALLRED_T = 2,
    parameter int PED_EXT  = 10,
    parameter int FLASH_T  = 1,
    localparam int DW      = (N_DIR > 1) ? $clog2(N_DIR) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tick,
    input  logic [N_DIR-1:0]     ped_req,
    input  logic                 flash,
    output logic [3*N_DIR-1:0]   light,
    output logic [N_DIR-1:0]     walk,
    output logic [DW-1:0]        cur_dir,
    output logic [1:0]           state_o
);

    typedef enum logic [1:0] {
        ST_ALLRED = 2'b00,
        ST_GREEN  = 2'b01,
        ST_YELLOW = 2'b10,
        ST_FLASH  = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] G_LD  = CNT_W'(GREEN_T - 1);
    localparam logic [CNT_W-1:0] GE_LD = CNT_W'(GREEN_T + PED_EXT - 1);
    localparam logic [CNT_W-1:0] Y_LD  = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] A_LD  = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] F_LD  = CNT_W'(FLASH_T - 1);
    localparam logic [DW-1:0]    LAST  = DW'(N_DIR - 1);

    state_t               state_q, state_n;
    logic [DW-1:0]        dir_q, dir_n;
    logic [CNT_W-1:0]     tmr_q, tmr_n;
    logic [N_DIR-1:0]     pend_q, pend_n;
    logic                 ext_q, ext_n;
    logic                 fph_q, fph_n;   // 1 = dark half of the flash cycle
    logic [3*N_DIR-1:0]   light_n;
    logic [N_DIR-1:0]     walk_n;

    always_comb begin
        state_n = state_q;
        dir_n   = dir_q;
        tmr_n   = tmr_q;
        ext_n   = ext_q;
        fph_n   = fph_q;
        pend_n  = pend_q | ped_req;
        if (tick) begin
            if (flash && (state_q != ST_FLASH)) begin
                state_n = ST_FLASH;
                tmr_n   = F_LD;
                fph_n   = 1'b0;
                ext_n   = 1'b0;
            end else if (!flash && (state_q == ST_FLASH)) begin
                state_n = ST_ALLRED;
                dir_n   = '0;
                tmr_n   = A_LD;
            end else if (tmr_q != '0) begin
                tmr_n = tmr_q - 1'b1;
            end else begin
                case (state_q)
                    ST_ALLRED: begin
                        // A request arriving on this very edge still earns the extension.
                        state_n        = ST_GREEN;
                        ext_n          = pend_n[dir_q];
                        pend_n[dir_q]  = 1'b0;
                        tmr_n          = ext_n ? GE_LD : G_LD;
                    end
                    ST_GREEN: begin
                        state_n = ST_YELLOW;
                        ext_n   = 1'b0;
                        tmr_n   = Y_LD;
                    end
                    ST_YELLOW: begin
                        state_n = ST_ALLRED;
                        dir_n   = (dir_q == LAST) ? '0 : dir_q + 1'b1;
                        tmr_n   = A_LD;
                    end
                    default: begin
                        fph_n = ~fph_q;
                        tmr_n = F_LD;
                    end
                endcase
            end
        end
    end

    // Outputs are decoded from next-state so they can be registered with it.
    always_comb begin
        light_n = '0;
        walk_n  = '0;
        for (int i = 0; i < N_DIR; i++) begin
            if (state_n == ST_FLASH)
                light_n[3*i +: 3] = fph_n ? 3'b000 : 3'b001;
            else if ((dir_n == DW'(i)) && (state_n == ST_GREEN))
                light_n[3*i +: 3] = 3'b010;
            else if ((dir_n == DW'(i)) && (state_n == ST_YELLOW))
                light_n[3*i +: 3] = 3'b001;
            else
                light_n[3*i +: 3] = 3'b100;
            walk_n[i] = (state_n == ST_GREEN) && ext_n && (dir_n == DW'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ALLRED;
            dir_q   <= '0;
            tmr_q   <= A_LD;
            pend_q  <= '0;
            ext_q   <= 1'b0;
            fph_q   <= 1'b0;
            light   <= {N_DIR{3'b100}};
            walk    <= '0;
        end else begin
            state_q <= state_n;
            dir_q   <= dir_n;
            tmr_q   <= tmr_n;
            pend_q  <= pend_n;
            ext_q   <= ext_n;
            fph_q   <= fph_n;
            light   <= light_n;
            walk    <= walk_n;
        end
    end

    assign cur_dir = dir_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_traffic_ctrl.sv
// Randomised and directed stimulus against a phase/elapsed-tick reference model; scoreboard queue drained by a monitor.
module tb_traffic_ctrl;

    localparam int ND = 4;
    localparam int DW = $clog2(ND);
    localparam int GT = 4, YT = 2, AT = 1, PE = 3, FT = 1;
    localparam int EW = 2 + DW + ND + 3*ND;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               tick = 1'b1;
    logic [ND-1:0]      ped_req = '0;
    logic               flash = 1'b0;
    logic [3*ND-1:0]    light;
    logic [ND-1:0]      walk;
    logic [DW-1:0]      cur_dir;
    logic [1:0]         state_o;

    int n_vec = 0;
    int n_err = 0;

    traffic_ctrl #(
        .N_DIR(ND), .CNT_W(8), .GREEN_T(GT), .YELLOW_T(YT),
        .ALLRED_T(AT), .PED_EXT(PE), .FLASH_T(FT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .ped_req(ped_req), .flash(flash),
        .light(light), .walk(walk), .cur_dir(cur_dir), .state_o(state_o)
    );

    always #5 clk = ~clk;

    // Reference model: phase kind (0 allred, 1 green, 2 yellow, 3 flash), owner, ticks elapsed vs duration.
    int            m_kind, m_dir, m_el, m_dur;
    bit            m_ext, m_fon;
    bit [ND-1:0]   m_pend;
    logic [EW-1:0] exp_q[$];

    task automatic m_reset();
        m_kind = 0; m_dir = 0; m_el = 0; m_dur = AT;
        m_ext = 0; m_fon = 1; m_pend = '0;
    endtask

    task automatic m_step(input bit tk, input logic [ND-1:0] pr, input bit fl);
        bit [ND-1:0] pn;
        pn = m_pend | pr;
        if (tk) begin
            if (fl && m_kind != 3) begin
                m_kind = 3; m_el = 0; m_dur = FT; m_fon = 1; m_ext = 0;
            end else if (!fl && m_kind == 3) begin
                m_kind = 0; m_dir = 0; m_el = 0; m_dur = AT;
            end else begin
                m_el++;
                if (m_el == m_dur) begin
                    m_el = 0;
                    case (m_kind)
                        0: begin
                            m_kind = 1; m_ext = pn[m_dir]; pn[m_dir] = 1'b0;
                            m_dur = GT + (m_ext ? PE : 0);
                        end
                        1: begin m_kind = 2; m_ext = 0; m_dur = YT; end
                        2: begin m_kind = 0; m_dir = (m_dir + 1) % ND; m_dur = AT; end
                        default: m_fon = !m_fon;
                    endcase
                end
            end
        end
        m_pend = pn;
    endtask

    function automatic logic [EW-1:0] model_out();
        logic [3*ND-1:0] lt;
        logic [ND-1:0]   wk;
        for (int i = 0; i < ND; i++) begin
            if (m_kind == 3)                     lt[3*i +: 3] = m_fon ? 3'b001 : 3'b000;
            else if (i == m_dir && m_kind == 1)  lt[3*i +: 3] = 3'b010;
            else if (i == m_dir && m_kind == 2)  lt[3*i +: 3] = 3'b001;
            else                                 lt[3*i +: 3] = 3'b100;
            wk[i] = (m_kind == 1) && m_ext && (i == m_dir);
        end
        return {2'(m_kind), DW'(m_dir), wk, lt};
    endfunction

    initial m_reset();

    always @(posedge clk) begin
        if (!rst_n) m_reset();
        else        m_step(tick, ped_req, flash);
        exp_q.push_back(model_out());
    end

    // Monitor: every cycle presents a full output word, compared against the oldest expectation.
    always @(posedge clk) begin
        logic [EW-1:0] e, a;
        int nr;
        #1;
        a = {state_o, cur_dir, walk, light};
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard_empty: got %h, no expectation queued", a);
        end else begin
            e = exp_q.pop_front();
            if (a !== e) begin
                n_err++;
                $display("FAIL outputs t=%0t: got st=%b dir=%0d walk=%b light=%b want st=%b dir=%0d walk=%b light=%b",
                         $time, a[EW-1 -: 2], a[EW-3 -: DW], a[3*ND +: ND], a[3*ND-1:0],
                         e[EW-1 -: 2], e[EW-3 -: DW], e[3*ND +: ND], e[3*ND-1:0]);
            end
        end
        if (state_o != 2'b11) begin
            nr = 0;
            for (int i = 0; i < ND; i++) if (light[3*i +: 3] != 3'b100) nr++;
            n_vec++;
            if (nr > 1) begin
                n_err++;
                $display("FAIL one_nonred: got %0d non-red groups, want at most 1 (light=%b)", nr, light);
            end
        end
    end

    task automatic wait_phase(input int k, input int d, input bit need_ext, input string nm);
        int n;
        n = 0;
        while (!(m_kind == k && m_dir == d && (!need_ext || m_ext)) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: phase not reached in 300 cycles, got kind=%0d dir=%0d want kind=%0d dir=%0d",
                     nm, m_kind, m_dir, k, d);
        end
    endtask

    initial begin
        bit fl;
        // Reset, then free-running cycle with no requests.
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);

        // Pedestrian pulse for group 1 while group 0 is green.
        wait_phase(1, 0, 0, "g0_green");
        ped_req = 4'b0010;
        @(negedge clk);
        ped_req = '0;
        repeat (60) @(negedge clk);

        // Slow timebase: one tick in three cycles.
        for (int c = 0; c < 90; c++) begin
            tick = (c % 3 == 0);
            @(negedge clk);
        end
        tick = 1'b1;

        // Flash requested during group 1 yellow, then released.
        wait_phase(2, 1, 0, "g1_yellow");
        flash = 1'b1;
        repeat (6) @(negedge clk);
        flash = 1'b0;
        repeat (20) @(negedge clk);

        // Asynchronous reset in the middle of an extended green.
        ped_req = 4'b0001;
        @(negedge clk);
        ped_req = '0;
        wait_phase(1, 0, 1, "g0_ext_green");
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({state_o, cur_dir, walk, light} !== {2'b00, DW'(0), ND'(0), {ND{3'b100}}}) begin
            n_err++;
            $display("FAIL async_reset: got st=%b dir=%0d walk=%b light=%b want st=00 dir=0 walk=0 all red",
                     state_o, cur_dir, walk, light);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);

        // Randomised tick, pedestrian and flash traffic.
        fl = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 149) == 0) fl = !fl;
            flash   = fl;
            tick    = ($urandom_range(0, 9) < 7);
            ped_req = ($urandom_range(0, 19) == 0) ? ND'($urandom) : '0;
            @(negedge clk);
        end
        flash = 1'b0;
        tick  = 1'b1;
        repeat (5) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
